// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: default reset/exception addresses, the fetch
// sequencer state encoding and a small PC arithmetic helper.
package cpu_pkg;

  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_4180;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_REQ  = 2'd1,
    S_DROP = 2'd2,
    S_HOLD = 2'd3
  } fetch_state_e;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/pc_redirect_sel.sv
// Priority select of the next fetch target: interrupt beats eret, and either one
// raises the redirect flag. Without a redirect the next-PC unit's address passes through.
module pc_redirect_sel
  import cpu_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  logic        int_req_i,
  input  logic        eret_i,
  input  logic [31:0] epc_i,
  input  logic [31:0] npc_i,
  output logic        redir_o,
  output logic [31:0] target_o
);

  // Interrupt > eret > sequential/branch next PC
  always_comb begin
    redir_o  = 1'b0;
    target_o = npc_i;
    if (int_req_i) begin
      redir_o  = 1'b1;
      target_o = EXC_VECTOR;
    end else if (eret_i) begin
      redir_o  = 1'b1;
      target_o = epc_i;
    end else begin
      redir_o  = 1'b0;
      target_o = npc_i;
    end
  end

endmodule

// File: rtl/pc_fetch_seq.sv
// Architectural PC owner and instruction fetch sequencer: drives a req/ack fetch
// port, squashes fetches overtaken by redirects and hands instr/PC to decode.
module pc_fetch_seq
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] npc_i,
  input  logic        stall_i,
  input  logic        int_req_i,
  input  logic        eret_i,
  input  logic [31:0] epc_i,
  output logic        if_req_o,
  output logic [31:0] if_addr_o,
  input  logic        if_ack_i,
  input  logic [31:0] if_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc4_o,
  output logic [31:0] instr_o,
  output logic        instr_vld_o,
  output logic        flush_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pc4_q, pc4_d;
  logic [31:0]  redir_pc_q, redir_pc_d;
  logic [31:0]  instr_q, instr_d;
  logic         vld_q, vld_d;
  logic         if_req_q, if_req_d;
  logic         flush_q, flush_d;

  logic         redir_s;
  logic [31:0]  target_s;

  pc_redirect_sel #(
    .EXC_VECTOR (EXC_VECTOR)
  ) u_redirect_sel (
    .int_req_i (int_req_i),
    .eret_i    (eret_i),
    .epc_i     (epc_i),
    .npc_i     (npc_i),
    .redir_o   (redir_s),
    .target_o  (target_s)
  );

  // Next-state and next-output computation for the fetch FSM
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    redir_pc_d = redir_pc_q;
    instr_d    = instr_q;
    vld_d      = vld_q;
    flush_d    = 1'b0;
    case (state_q)
      S_BOOT: begin
        state_d = S_REQ;
        if (redir_s) begin
          pc_d    = target_s;
          flush_d = 1'b1;
        end else begin
          pc_d = pc_q;
        end
      end
      S_REQ: begin
        if (redir_s) begin
          flush_d = 1'b1;
          if (if_ack_i) begin
            pc_d = target_s;
          end else begin
            // The memory transaction cannot be aborted; remember where to go once it drains.
            redir_pc_d = target_s;
            state_d    = S_DROP;
          end
        end else if (if_ack_i) begin
          instr_d = if_rdata_i;
          vld_d   = 1'b1;
          state_d = S_HOLD;
        end else begin
          state_d = S_REQ;
        end
      end
      S_DROP: begin
        if (if_ack_i) begin
          state_d = S_REQ;
          if (redir_s) begin
            pc_d    = target_s;
            flush_d = 1'b1;
          end else begin
            pc_d = redir_pc_q;
          end
        end else if (redir_s) begin
          redir_pc_d = target_s;
          flush_d    = 1'b1;
        end else begin
          state_d = S_DROP;
        end
      end
      S_HOLD: begin
        if (redir_s) begin
          pc_d    = target_s;
          vld_d   = 1'b0;
          flush_d = 1'b1;
          state_d = S_REQ;
        end else if (stall_i) begin
          state_d = S_HOLD;
        end else begin
          pc_d    = npc_i;
          vld_d   = 1'b0;
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_BOOT;
        vld_d   = 1'b0;
      end
    endcase
    if_req_d = (state_d == S_REQ) || (state_d == S_DROP);
    pc4_d    = pc_plus4(pc_d);
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_PC;
      pc4_q      <= pc_plus4(RESET_PC);
      redir_pc_q <= RESET_PC;
      instr_q    <= 32'd0;
      vld_q      <= 1'b0;
      if_req_q   <= 1'b0;
      flush_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc4_q      <= pc4_d;
      redir_pc_q <= redir_pc_d;
      instr_q    <= instr_d;
      vld_q      <= vld_d;
      if_req_q   <= if_req_d;
      flush_q    <= flush_d;
    end
  end

  assign if_req_o    = if_req_q;
  assign if_addr_o   = pc_q;
  assign pc_o        = pc_q;
  assign pc4_o       = pc4_q;
  assign instr_o     = instr_q;
  assign instr_vld_o = vld_q;
  assign flush_o     = flush_q;

endmodule

// File: tb/tb_pc_fetch_seq.sv
// Directed bench for pc_fetch_seq: stimulus pushes expected fetch handshakes and
// delivered instructions into queues; a negedge monitor pops and compares them.
module tb_pc_fetch_seq;

  logic        clk;
  logic        reset;
  logic [31:0] npc_i;
  logic        stall_i;
  logic        int_req_i;
  logic        eret_i;
  logic [31:0] epc_i;
  logic        if_req_o;
  logic [31:0] if_addr_o;
  logic        if_ack_i;
  logic [31:0] if_rdata_i;
  logic [31:0] pc_o;
  logic [31:0] pc4_o;
  logic [31:0] instr_o;
  logic        instr_vld_o;
  logic        flush_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_fetch[$];
  logic [63:0] exp_instr[$];

  pc_fetch_seq dut (
    .clk         (clk),
    .reset       (reset),
    .npc_i       (npc_i),
    .stall_i     (stall_i),
    .int_req_i   (int_req_i),
    .eret_i      (eret_i),
    .epc_i       (epc_i),
    .if_req_o    (if_req_o),
    .if_addr_o   (if_addr_o),
    .if_ack_i    (if_ack_i),
    .if_rdata_i  (if_rdata_i),
    .pc_o        (pc_o),
    .pc4_o       (pc4_o),
    .instr_o     (instr_o),
    .instr_vld_o (instr_vld_o),
    .flush_o     (flush_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Precondition: DUT in S_REQ at addr. Zero-wait ack, ends in S_HOLD.
  task automatic fetch_hold(input logic [31:0] addr, input logic [31:0] data);
    chk("req_addr", if_addr_o, addr);
    if_ack_i   = 1'b1;
    if_rdata_i = data;
    exp_fetch.push_back(addr);
    exp_instr.push_back({addr, data});
    step();
    if_ack_i   = 1'b0;
    if_rdata_i = 32'd0;
    chk("hold_req", 32'(if_req_o), 32'd0);
    chk("hold_vld", 32'(instr_vld_o), 32'd1);
    chk("hold_flush", 32'(flush_o), 32'd0);
  endtask

  task automatic advance(input logic [31:0] nxt);
    npc_i = nxt;
    step();
    chk("adv_pc", pc_o, nxt);
    chk("adv_req", 32'(if_req_o), 32'd1);
    chk("adv_vld", 32'(instr_vld_o), 32'd0);
  endtask

  // Monitor: compare handshakes and newly delivered instructions against the queues
  initial begin
    logic vld_prev;
    logic [63:0] e;
    vld_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (if_req_o && if_ack_i) begin
          if (exp_fetch.size() == 0) begin
            checks++; errors++;
            $display("FAIL fetch_unexpected: addr %08h, none expected", if_addr_o);
          end else begin
            chk("fetch_addr", if_addr_o, exp_fetch.pop_front());
          end
        end
        if (instr_vld_o && !vld_prev) begin
          if (exp_instr.size() == 0) begin
            checks++; errors++;
            $display("FAIL instr_unexpected: pc %08h instr %08h, none expected", pc_o, instr_o);
          end else begin
            e = exp_instr.pop_front();
            chk("instr_pc", pc_o, e[63:32]);
            chk("instr_data", instr_o, e[31:0]);
          end
        end
      end
      vld_prev = instr_vld_o;
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; npc_i = 32'd0; stall_i = 1'b0; int_req_i = 1'b0;
    eret_i = 1'b0; epc_i = 32'd0; if_ack_i = 1'b0; if_rdata_i = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", pc_o, 32'h0000_3000);
    chk("rst_pc4", pc4_o, 32'h0000_3004);
    chk("rst_instr", instr_o, 32'd0);
    chk("rst_vld", 32'(instr_vld_o), 32'd0);
    chk("rst_req", 32'(if_req_o), 32'd0);
    chk("rst_flush", 32'(flush_o), 32'd0);
    reset = 1'b0;
    step();
    chk("boot_req", 32'(if_req_o), 32'd1);

    // 1: zero-wait sequential fetch
    fetch_hold(32'h0000_3000, 32'hA000_0001);
    advance(32'h0000_3004);
    fetch_hold(32'h0000_3004, 32'hA000_0002);
    advance(32'h0000_3008);
    fetch_hold(32'h0000_3008, 32'hA000_0003);
    advance(32'h0000_300C);

    // 2: stall in S_HOLD
    fetch_hold(32'h0000_300C, 32'h1234_5678);
    stall_i = 1'b1;
    npc_i   = 32'h0000_9990;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", pc_o, 32'h0000_300C);
      chk("stall_instr", instr_o, 32'h1234_5678);
      chk("stall_req", 32'(if_req_o), 32'd0);
      chk("stall_vld", 32'(instr_vld_o), 32'd1);
    end
    stall_i = 1'b0;
    advance(32'h0000_3010);

    // 3: interrupt in S_REQ, ack two cycles later is squashed
    int_req_i = 1'b1;
    step();
    int_req_i = 1'b0;
    chk("int_flush", 32'(flush_o), 32'd1);
    chk("drop_addr", if_addr_o, 32'h0000_3010);
    step();
    chk("drop_flush_low", 32'(flush_o), 32'd0);
    chk("drop_req", 32'(if_req_o), 32'd1);
    if_ack_i   = 1'b1;
    if_rdata_i = 32'hDEAD_0001;
    exp_fetch.push_back(32'h0000_3010);
    step();
    if_ack_i = 1'b0;
    chk("drop_vld", 32'(instr_vld_o), 32'd0);
    chk("drop_pc", pc_o, 32'h0000_4180);
    fetch_hold(32'h0000_4180, 32'hB000_0001);

    // 4: int + eret together in S_HOLD -> interrupt wins; then eret alone
    int_req_i = 1'b1; eret_i = 1'b1; epc_i = 32'h0000_3010;
    step();
    int_req_i = 1'b0; eret_i = 1'b0;
    chk("interet_flush", 32'(flush_o), 32'd1);
    chk("interet_pc", pc_o, 32'h0000_4180);
    chk("interet_vld", 32'(instr_vld_o), 32'd0);
    fetch_hold(32'h0000_4180, 32'hB000_0002);
    eret_i = 1'b1; epc_i = 32'h0000_3010;
    step();
    eret_i = 1'b0;
    chk("eret_flush", 32'(flush_o), 32'd1);
    chk("eret_pc", pc_o, 32'h0000_3010);
    fetch_hold(32'h0000_3010, 32'hB000_0003);
    advance(32'h0000_3014);

    // 5: two redirects in S_DROP, newest wins
    int_req_i = 1'b1;
    step();
    int_req_i = 1'b0;
    chk("drop2_flush1", 32'(flush_o), 32'd1);
    eret_i = 1'b1; epc_i = 32'h0000_3020;
    step();
    eret_i = 1'b0;
    chk("drop2_flush2", 32'(flush_o), 32'd1);
    chk("drop2_addr", if_addr_o, 32'h0000_3014);
    if_ack_i = 1'b1;
    exp_fetch.push_back(32'h0000_3014);
    step();
    if_ack_i = 1'b0;
    chk("drop2_flush_low", 32'(flush_o), 32'd0);
    chk("drop2_pc", pc_o, 32'h0000_3020);
    fetch_hold(32'h0000_3020, 32'hC000_0001);

    // pc4 wrap at the top of the address space
    eret_i = 1'b1; epc_i = 32'hFFFF_FFFC;
    step();
    eret_i = 1'b0;
    chk("wrap_pc", pc_o, 32'hFFFF_FFFC);
    chk("wrap_pc4", pc4_o, 32'h0000_0000);
    fetch_hold(32'hFFFF_FFFC, 32'hC000_0002);
    advance(32'h0000_3024);
    chk("pc4_seq", pc4_o, 32'h0000_3028);

    // Two-cycle memory latency without redirect
    step();
    step();
    chk("wait_req", 32'(if_req_o), 32'd1);
    chk("wait_addr", if_addr_o, 32'h0000_3024);
    fetch_hold(32'h0000_3024, 32'hD000_0001);
    advance(32'h0000_3028);

    // 6: reset mid-fetch, stray ack in S_BOOT
    reset = 1'b1;
    #1;
    chk("midrst_req", 32'(if_req_o), 32'd0);
    chk("midrst_pc", pc_o, 32'h0000_3000);
    chk("midrst_instr", instr_o, 32'd0);
    chk("midrst_vld", 32'(instr_vld_o), 32'd0);
    chk("midrst_flush", 32'(flush_o), 32'd0);
    step();
    reset      = 1'b0;
    if_ack_i   = 1'b1;
    if_rdata_i = 32'hDEAD_0002;
    step();
    chk("stray_vld", 32'(instr_vld_o), 32'd0);
    chk("stray_instr", instr_o, 32'd0);
    chk("stray_req", 32'(if_req_o), 32'd1);
    fetch_hold(32'h0000_3000, 32'hE000_0001);
    step();
    step();

    chk("fetch_queue_empty", 32'(exp_fetch.size()), 32'd0);
    chk("instr_queue_empty", 32'(exp_instr.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
